// File: rtl/demux1x2_stage.sv
// demux1x2_stage: registered 1-to-2 demultiplexing pipeline stage.
// Each word arrives with a select bit and is delivered to exactly one of two
// consumers, in strict arrival order. A two-entry skid buffer (head + skid)
// keeps full throughput while in_ready is driven straight from a register.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   flush                 synchronous discard of all buffered entries
//   in_valid/in_ready     upstream handshake; in_data word, in_sel destination
//   out1_valid/out1_ready consumer 1 handshake (head.sel == 0), out1_data
//   out2_valid/out2_ready consumer 2 handshake (head.sel == 1), out2_data
//   out1_count/out2_count delivered-word counters (only with DEMUX_COUNT_EN)
//
// Optional feature macro: DEMUX_COUNT_EN (adds the two 16-bit counters).
module demux1x2_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      out1_count,
  output logic [15:0]      out2_count
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sel;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_d;
  entry_t head, head_d;
  entry_t skid, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   drain;
  logic   hs1;
  logic   hs2;

  assign in_entry = {in_data, in_sel};
  assign accept   = in_valid && in_ready;
  assign hs1      = out1_valid && out1_ready;
  assign hs2      = out2_valid && out2_ready;
  assign drain    = hs1 || hs2;

  // State and storage registers; in_ready is precomputed from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      head     <= '0;
      skid     <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_d;
      head     <= head_d;
      skid     <= skid_d;
      in_ready <= (state_d != TWO);
    end
  end

  // Next state and storage updates; flush wins over accept and drain.
  always_comb begin
    state_d = state;
    head_d  = head;
    skid_d  = skid;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_d  = in_entry;
            state_d = TWO;
          end else if (!accept && drain) begin
            state_d = EMPTY;
          end else if (accept && drain) begin
            head_d  = in_entry;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            head_d  = skid;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs decoded from registered state and head entry.
  always_comb begin
    out1_valid = (state != EMPTY) && !head.sel;
    out2_valid = (state != EMPTY) && head.sel;
    out1_data  = head.data;
    out2_data  = head.data;
  end

`ifdef DEMUX_COUNT_EN
  // Delivered-word counters; they count through flush and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_count <= '0;
      out2_count <= '0;
    end else begin
      if (hs1) out1_count <= out1_count + CNT_W'(1);
      if (hs2) out2_count <= out2_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux1x2_stage.sv
module tb_demux1x2_stage;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             out1_valid;
  logic             out1_ready = 1'b0;
  logic [WIDTH-1:0] out1_data;
  logic             out2_valid;
  logic             out2_ready = 1'b0;
  logic [WIDTH-1:0] out2_data;
`ifdef DEMUX_COUNT_EN
  logic [15:0]      out1_count;
  logic [15:0]      out2_count;
`endif

  int passed = 0;
  int total  = 0;

  demux1x2_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data)
`ifdef DEMUX_COUNT_EN
    , .out1_count(out1_count), .out2_count(out2_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: an ordered queue of at most two {data, sel} words.
  typedef struct {
    logic [WIDTH-1:0] data;
    logic             sel;
  } word_t;
  word_t       q[$];
  logic [15:0] m_cnt1 = '0;
  logic [15:0] m_cnt2 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cnt1 = '0;
      m_cnt2 = '0;
    end else begin
      bit acc;
      bit drn;
      word_t w;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && (q[0].sel ? out2_ready : out1_ready);
      if (drn) begin
        if (q[0].sel) m_cnt2 = m_cnt2 + 16'd1;
        else          m_cnt1 = m_cnt1 + 16'd1;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          w.data = in_data;
          w.sel  = in_sel;
          q.push_back(w);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit ne;
    ne = (q.size() > 0);
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out1_valid", 32'(out1_valid), 32'(ne && !q[0].sel));
    chk("out2_valid", 32'(out2_valid), 32'(ne && q[0].sel));
    if (ne) begin
      chk("out1_data", 32'(out1_data), 32'(q[0].data));
      chk("out2_data", 32'(out2_data), 32'(q[0].data));
    end
`ifdef DEMUX_COUNT_EN
    chk("out1_count", 32'(out1_count), 32'(m_cnt1));
    chk("out2_count", 32'(out2_count), 32'(m_cnt2));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [WIDTH-1:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out2_valid", 32'(out2_valid), 32'd0);
    chk("rst_data", 32'(out1_data), 32'h0000);
    rst = 1'b0;
    step();

    // Streaming with both consumers ready
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put(16'(i), 1'((i - 1) % 2));
      step();
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if ((i % 2) == 1) chk("stream_out1", {31'd0, out1_valid} << 16 | 32'(out1_data), 32'h1_0000 | 32'(i));
      else              chk("stream_out2", {31'd0, out2_valid} << 16 | 32'(out2_data), 32'h1_0000 | 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", 32'({out1_valid, out2_valid}), 32'd0);

    // Back-pressure: stalled out1 head blocks the out2 word behind it
    out1_ready = 1'b0;
    put(16'hA5A5, 1'b0);
    step();
    chk("bp_head", 32'(out1_data), 32'hA5A5);
    chk("bp_in_ready1", 32'(in_ready), 32'd1);
    put(16'h5A5A, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_in_ready0", 32'(in_ready), 32'd0);
    chk("bp_out2_blocked", 32'(out2_valid), 32'd0);
    step();
    chk("bp_hold", 32'({out1_valid, out1_data}), 32'h1_A5A5);
    out1_ready = 1'b1;
    step();
    chk("bp_second", 32'({out2_valid, out2_data}), 32'h1_5A5A);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_empty", 32'({out1_valid, out2_valid}), 32'd0);

    // Flush in TWO with a word offered in the same cycle
    out1_ready = 1'b0;
    put(16'h1111, 1'b0);
    step();
    put(16'h2222, 1'b1);
    step();
    flush = 1'b1;
    put(16'hBEEF, 1'b1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'({out1_valid, out2_valid}), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_beef", 32'({out1_valid, out2_valid}), 32'd0);
    end

    // Accept and drain in the same cycle stays in ONE
    put(16'h3333, 1'b0);
    step();
    put(16'h4444, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ad_head", 32'({out2_valid, out2_data}), 32'h1_4444);
    chk("ad_out1_off", 32'(out1_valid), 32'd0);
    chk("ad_in_ready", 32'(in_ready), 32'd1);
    step();

    // Reset mid-stream with two entries buffered, checked before any edge
    out1_ready = 1'b0;
    put(16'h7777, 1'b0);
    step();
    put(16'h8888, 1'b1);
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'({out1_valid, out2_valid}), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_data", 32'(out1_data), 32'h0000);
    step();
    rst = 1'b0;
    step();

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 65537 deliveries on out1
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      put(16'(i), 1'b0);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("wrap_out1_count", 32'(out1_count), 32'h0001);
    chk("wrap_out2_count", 32'(out2_count), 32'h0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
